// File: rtl/instr_decode_stage_if.sv
// ---------------------------------------------------------------------------
// instr_decode_stage_if
// Handshake and decoded-field bundle for the instruction decode stage.
//   Upstream side  : in_valid, in_ready, instr_in, pc_in, flush
//   Downstream side: out_valid, out_ready, opcode, rs, rt, rd, funct,
//                    immediateIN, U, pc_out, illegal
// modport master : the environment (fetch + execute) driving the stage
// modport slave  : the decode stage itself
// ---------------------------------------------------------------------------
interface instr_decode_stage_if #(
  parameter int IW  = 32,
  parameter int N   = 16,
  parameter int RW  = 5,
  parameter int PCW = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  instr_in;
  logic [PCW-1:0] pc_in;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [5:0]     opcode;
  logic [RW-1:0]  rs;
  logic [RW-1:0]  rt;
  logic [RW-1:0]  rd;
  logic [5:0]     funct;
  logic [N-1:0]   immediateIN;
  logic           U;
  logic [PCW-1:0] pc_out;
  logic           illegal;

  modport master (
    output in_valid, instr_in, pc_in, flush, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, rd, funct,
           immediateIN, U, pc_out, illegal
  );

  modport slave (
    input  in_valid, instr_in, pc_in, flush, out_ready,
    output in_ready, out_valid, opcode, rs, rt, rd, funct,
           immediateIN, U, pc_out, illegal
  );
endinterface

// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
// Pipeline register + field decode sitting in front of immediate_extension.
// Instructions are decoded at accept time and held in a main register (M)
// that drives every output; a one-entry skid register (S) absorbs the beat
// that arrives while M is stalled, so in_ready depends only on state.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : instr_decode_stage_if.slave (handshakes, flush, decoded fields)
//
// Optional feature macro: DECODE_ILLEGAL_EN
//   defined     -> illegal flags opcodes outside the supported set
//   not defined -> illegal is constant 0
// ---------------------------------------------------------------------------
module instr_decode_stage #(
  parameter int IW  = 32,
  parameter int N   = 16,
  parameter int RW  = 5,
  parameter int PCW = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_decode_stage_if.slave   bus
);

  typedef struct packed {
    logic [5:0]     opcode;
    logic [RW-1:0]  rs;
    logic [RW-1:0]  rt;
    logic [RW-1:0]  rd;
    logic [5:0]     funct;
    logic [N-1:0]   imm;
    logic           u;
    logic           illegal;
    logic [PCW-1:0] pc;
  } dec_t;

  // Split an instruction into its fields and derive the extension controls.
  function automatic dec_t decode(input logic [IW-1:0] instr,
                                  input logic [PCW-1:0] pc);
    dec_t d;
    d.opcode = instr[31:26];
    d.rs     = instr[25:21];
    d.rt     = instr[20:16];
    d.rd     = instr[15:11];
    d.funct  = instr[5:0];
    d.imm    = instr[N-1:0];
    d.pc     = pc;
    // Logical immediates (andi/ori/xori/lui) are zero-extended.
    case (instr[31:26])
      6'h0C, 6'h0D, 6'h0E, 6'h0F: d.u = 1'b1;
      default:                    d.u = 1'b0;
    endcase
`ifdef DECODE_ILLEGAL_EN
    case (instr[31:26])
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
      6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: d.illegal = 1'b0;
      default:                                  d.illegal = 1'b1;
    endcase
`else
    d.illegal = 1'b0;
`endif
    return d;
  endfunction

  dec_t m_q;
  dec_t s_q;
  logic m_valid_q;
  logic s_valid_q;

  logic accept_s;
  logic xfer_s;
  dec_t dec_s;

  // Handshake qualifiers and the decode of the incoming beat.
  always_comb begin
    accept_s = bus.in_valid && !s_valid_q;
    xfer_s   = m_valid_q && bus.out_ready;
    dec_s    = decode(bus.instr_in, bus.pc_in);
  end

  // Main/skid register update; flush wins over any accept or transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_q       <= '0;
      s_q       <= '0;
    end else if (bus.flush) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else if (!m_valid_q || xfer_s) begin
      // M is free this cycle: the older skid beat goes first. in_ready was
      // low whenever S is valid, so no new beat can compete with it.
      if (s_valid_q) begin
        m_q       <= s_q;
        m_valid_q <= 1'b1;
        s_valid_q <= 1'b0;
      end else if (accept_s) begin
        m_q       <= dec_s;
        m_valid_q <= 1'b1;
      end else begin
        m_valid_q <= 1'b0;
      end
    end else begin
      // M stalled: park the new beat in S, which drops in_ready next cycle.
      if (accept_s) begin
        s_q       <= dec_s;
        s_valid_q <= 1'b1;
      end else begin
        s_valid_q <= s_valid_q;
      end
    end
  end

  assign bus.in_ready    = !s_valid_q;
  assign bus.out_valid   = m_valid_q;
  assign bus.opcode      = m_q.opcode;
  assign bus.rs          = m_q.rs;
  assign bus.rt          = m_q.rt;
  assign bus.rd          = m_q.rd;
  assign bus.funct       = m_q.funct;
  assign bus.immediateIN = m_q.imm;
  assign bus.U           = m_q.u;
  assign bus.pc_out      = m_q.pc;
  assign bus.illegal     = m_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_stage
// Directed self-checking bench for instr_decode_stage.
// ---------------------------------------------------------------------------
module tb_instr_decode_stage;
  localparam int IW  = 32;
  localparam int N   = 16;
  localparam int RW  = 5;
  localparam int PCW = 32;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  instr_decode_stage_if #(.IW(IW), .N(N), .RW(RW), .PCW(PCW)) bus_if ();

  instr_decode_stage #(.IW(IW), .N(N), .RW(RW), .PCW(PCW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus_if.in_valid = v;
    bus_if.instr_in = instr;
    bus_if.pc_in    = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    bus_if.flush     = 1'b0;
    bus_if.out_ready = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (bus_if.out_valid !== 1'b0) $display("FAIL reset_out_valid got %h want 0", bus_if.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.in_ready !== 1'b1) $display("FAIL reset_in_ready got %h want 1", bus_if.in_ready);
    else pass_cnt++;
    total_cnt++;
    if ({bus_if.opcode, bus_if.immediateIN, bus_if.U, bus_if.pc_out, bus_if.illegal} !== 56'h0)
      $display("FAIL reset_fields got op=%h imm=%h U=%h pc=%h ill=%h want all 0",
               bus_if.opcode, bus_if.immediateIN, bus_if.U, bus_if.pc_out, bus_if.illegal);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++;
    if (bus_if.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %h want 1", bus_if.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_decode();
    logic [31:0] ext;
    bus_if.out_ready = 1'b1;
    drive(1'b1, 32'h350800FF, 32'h100);
    tick();
    total_cnt++;
    if ({bus_if.out_valid, bus_if.opcode, bus_if.rs, bus_if.rt, bus_if.rd, bus_if.funct}
        !== {1'b1, 6'h0D, 5'd8, 5'd8, 5'd0, 6'h3F})
      $display("FAIL ori_fields got v=%h op=%h rs=%0d rt=%0d rd=%0d fn=%h want v=1 op=0d rs=8 rt=8 rd=0 fn=3f",
               bus_if.out_valid, bus_if.opcode, bus_if.rs, bus_if.rt, bus_if.rd, bus_if.funct);
    else pass_cnt++;
    total_cnt++;
    if ({bus_if.immediateIN, bus_if.U, bus_if.pc_out} !== {16'h00FF, 1'b1, 32'h100})
      $display("FAIL ori_imm got imm=%h U=%h pc=%h want imm=00ff U=1 pc=100",
               bus_if.immediateIN, bus_if.U, bus_if.pc_out);
    else pass_cnt++;
    drive(1'b1, 32'h2108FFF6, 32'h104);
    tick();
    total_cnt++;
    if ({bus_if.out_valid, bus_if.opcode, bus_if.rd, bus_if.funct, bus_if.immediateIN, bus_if.U, bus_if.pc_out}
        !== {1'b1, 6'h08, 5'd31, 6'h36, 16'hFFF6, 1'b0, 32'h104})
      $display("FAIL addi_fields got v=%h op=%h rd=%0d fn=%h imm=%h U=%h pc=%h want v=1 op=08 rd=31 fn=36 imm=fff6 U=0 pc=104",
               bus_if.out_valid, bus_if.opcode, bus_if.rd, bus_if.funct, bus_if.immediateIN, bus_if.U, bus_if.pc_out);
    else pass_cnt++;
    ext = bus_if.U ? {16'h0000, bus_if.immediateIN} : {{16{bus_if.immediateIN[15]}}, bus_if.immediateIN};
    total_cnt++;
    if (ext !== 32'hFFFFFFF6) $display("FAIL addi_extend got %h want fffffff6", ext);
    else pass_cnt++;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    total_cnt++;
    if (bus_if.out_valid !== 1'b0) $display("FAIL decode_drain got %h want 0", bus_if.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bus_if.out_ready = 1'b0;
    drive(1'b1, 32'h350800FF, 32'h200);
    tick();
    total_cnt++;
    if (bus_if.in_ready !== 1'b1) $display("FAIL bp_first_ready got %h want 1", bus_if.in_ready);
    else pass_cnt++;
    drive(1'b1, 32'h2108FFF6, 32'h204);
    tick();
    total_cnt++;
    if ({bus_if.in_ready, bus_if.out_valid, bus_if.pc_out, bus_if.opcode} !== {1'b0, 1'b1, 32'h200, 6'h0D})
      $display("FAIL bp_full got rdy=%h v=%h pc=%h op=%h want rdy=0 v=1 pc=200 op=0d",
               bus_if.in_ready, bus_if.out_valid, bus_if.pc_out, bus_if.opcode);
    else pass_cnt++;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    total_cnt++;
    if ({bus_if.in_ready, bus_if.out_valid, bus_if.pc_out, bus_if.immediateIN} !== {1'b0, 1'b1, 32'h200, 16'h00FF})
      $display("FAIL bp_hold got rdy=%h v=%h pc=%h imm=%h want rdy=0 v=1 pc=200 imm=00ff",
               bus_if.in_ready, bus_if.out_valid, bus_if.pc_out, bus_if.immediateIN);
    else pass_cnt++;
    bus_if.out_ready = 1'b1;
    tick();
    total_cnt++;
    if ({bus_if.in_ready, bus_if.out_valid, bus_if.pc_out, bus_if.immediateIN, bus_if.U}
        !== {1'b1, 1'b1, 32'h204, 16'hFFF6, 1'b0})
      $display("FAIL bp_second got rdy=%h v=%h pc=%h imm=%h U=%h want rdy=1 v=1 pc=204 imm=fff6 U=0",
               bus_if.in_ready, bus_if.out_valid, bus_if.pc_out, bus_if.immediateIN, bus_if.U);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus_if.in_ready, bus_if.out_valid} !== 2'b10)
      $display("FAIL bp_empty got rdy=%h v=%h want rdy=1 v=0", bus_if.in_ready, bus_if.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_throughput();
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h21080000 | 32'(i), 32'h100 + 32'(4 * i));
      tick();
      total_cnt++;
      if ({bus_if.out_valid, bus_if.in_ready, bus_if.pc_out, bus_if.immediateIN}
          !== {1'b1, 1'b1, 32'h100 + 32'(4 * i), 16'(i)})
        $display("FAIL stream_%0d got v=%h rdy=%h pc=%h imm=%h want v=1 rdy=1 pc=%h imm=%h",
                 i, bus_if.out_valid, bus_if.in_ready, bus_if.pc_out, bus_if.immediateIN,
                 32'h100 + 32'(4 * i), 16'(i));
      else pass_cnt++;
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    total_cnt++;
    if (bus_if.out_valid !== 1'b0) $display("FAIL stream_end got %h want 0", bus_if.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    bus_if.out_ready = 1'b0;
    drive(1'b1, 32'h350800FF, 32'h300);
    tick();
    drive(1'b1, 32'h2108FFF6, 32'h304);
    tick();
    drive(1'b1, 32'h8C000000, 32'h308);
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    total_cnt++;
    if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01)
      $display("FAIL flush_state got v=%h rdy=%h want v=0 rdy=1", bus_if.out_valid, bus_if.in_ready);
    else pass_cnt++;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_if.out_valid === 1'b1) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL flush_leak got %0d beats want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus_if.out_ready = 1'b1;
    drive(1'b1, 32'h350800FF, 32'h400);
    tick();
    drive(1'b1, 32'h2108FFF6, 32'h404);
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({bus_if.out_valid, bus_if.U, bus_if.in_ready} !== 3'b001)
      $display("FAIL reset_async got v=%h U=%h rdy=%h want v=0 U=0 rdy=1",
               bus_if.out_valid, bus_if.U, bus_if.in_ready);
    else pass_cnt++;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if (bus_if.out_valid !== 1'b0) $display("FAIL reset_lost got %h want 0", bus_if.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    bus_if.out_ready = 1'b1;
    drive(1'b1, 32'hFC000000, 32'h500);
    tick();
`ifdef DECODE_ILLEGAL_EN
    total_cnt++;
    if ({bus_if.illegal, bus_if.opcode, bus_if.out_valid} !== {1'b1, 6'h3F, 1'b1})
      $display("FAIL illegal_op got ill=%h op=%h v=%h want ill=1 op=3f v=1",
               bus_if.illegal, bus_if.opcode, bus_if.out_valid);
    else pass_cnt++;
`else
    total_cnt++;
    if ({bus_if.illegal, bus_if.opcode, bus_if.out_valid} !== {1'b0, 6'h3F, 1'b1})
      $display("FAIL illegal_tied got ill=%h op=%h v=%h want ill=0 op=3f v=1",
               bus_if.illegal, bus_if.opcode, bus_if.out_valid);
    else pass_cnt++;
`endif
    drive(1'b1, 32'hAC000000, 32'h504);
    tick();
    total_cnt++;
    if ({bus_if.illegal, bus_if.opcode, bus_if.U} !== {1'b0, 6'h2B, 1'b0})
      $display("FAIL legal_sw got ill=%h op=%h U=%h want ill=0 op=2b U=0",
               bus_if.illegal, bus_if.opcode, bus_if.U);
    else pass_cnt++;
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_decode();
    test_backpressure();
    test_throughput();
    test_flush();
    test_reset_mid();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
